// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions: next-PC select encodings and the nop word.
package mips_pipe_pkg;

    localparam logic [1:0] ADDR_SEQ    = 2'b00;
    localparam logic [1:0] ADDR_JUMP   = 2'b01;
    localparam logic [1:0] ADDR_BRANCH = 2'b10;
    localparam logic [1:0] ADDR_JR     = 2'b11;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // J-type target: upper nibble comes from the delay-slot PC held in IF/ID.
    function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                                input logic [25:0] jump_field);
        return {pc_plus4[31:28], jump_field, 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/if_stage_ctrl.sv
// Instruction-fetch stage: PC register, next-PC select, IF/ID register,
// registered ID/EX kill flag and stall/bubble/redirect debug counters.
module if_stage_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             IF_write,
    input  logic             PC_write,
    input  logic             bubble,
    input  logic [1:0]       addrSel,
    input  logic [25:0]      JumpField,
    input  logic [31:0]      BranchTarget,
    input  logic [31:0]      JrTarget,
    input  logic [31:0]      InstrIn,
    input  logic             CntClr,
    output logic [31:0]      PC,
    output logic [31:0]      IFID_Instr,
    output logic [31:0]      IFID_PCPlus4,
    output logic             IFID_Valid,
    output logic             IDEX_Kill,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] BubbleCnt,
    output logic [CNT_W-1:0] RedirectCnt
);
    import mips_pipe_pkg::*;

    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        stall_ev;
    logic        redirect_ev;

    assign pc_plus4 = PC + 32'd4;

    always_comb begin
        next_pc = pc_plus4;
        unique case (addrSel)
            ADDR_SEQ:    next_pc = pc_plus4;
            ADDR_JUMP:   next_pc = jump_target(IFID_PCPlus4, JumpField);
            ADDR_BRANCH: next_pc = BranchTarget;
            ADDR_JR:     next_pc = JrTarget;
            default:     next_pc = pc_plus4;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            PC <= RESET_PC;
        end else if (PC_write) begin
            PC <= next_pc;
        end
    end

    // IF/ID stays frozen on IF_write=0 even when the PC is redirected.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            IFID_Instr   <= NOP_INSTR;
            IFID_PCPlus4 <= 32'h0;
            IFID_Valid   <= 1'b0;
        end else if (IF_write) begin
            IFID_Instr   <= InstrIn;
            IFID_PCPlus4 <= pc_plus4;
            IFID_Valid   <= 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            IDEX_Kill <= 1'b0;
        end else begin
            IDEX_Kill <= bubble;
        end
    end

    // A redirect only counts when the PC actually takes the new target.
    assign stall_ev    = ~PC_write;
    assign redirect_ev = PC_write && (addrSel != ADDR_SEQ);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .Clk (Clk),
        .Rst (Rst),
        .clr (CntClr),
        .inc (stall_ev),
        .cnt (StallCnt)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .Clk (Clk),
        .Rst (Rst),
        .clr (CntClr),
        .inc (bubble),
        .cnt (BubbleCnt)
    );

    sat_counter #(.W(CNT_W)) u_redirect_cnt (
        .Clk (Clk),
        .Rst (Rst),
        .clr (CntClr),
        .inc (redirect_ev),
        .cnt (RedirectCnt)
    );

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Bench for if_stage_ctrl: directed vector table, a saturation sequence on a
// narrow-counter instance, then random traffic against a behavioural model.
module tb_if_stage_ctrl;

    logic        Clk = 1'b0;
    logic        Rst, IF_write, PC_write, bubble, CntClr;
    logic [1:0]  addrSel;
    logic [25:0] JumpField;
    logic [31:0] BranchTarget, JrTarget, InstrIn;

    logic [31:0] PC, IFID_Instr, IFID_PCPlus4;
    logic        IFID_Valid, IDEX_Kill;
    logic [31:0] StallCnt, BubbleCnt, RedirectCnt;

    logic [31:0] s_PC, s_IFID_Instr, s_IFID_PCPlus4;
    logic        s_IFID_Valid, s_IDEX_Kill;
    logic [1:0]  s_StallCnt, s_BubbleCnt, s_RedirectCnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    if_stage_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .Clk(Clk), .Rst(Rst), .IF_write(IF_write), .PC_write(PC_write),
        .bubble(bubble), .addrSel(addrSel), .JumpField(JumpField),
        .BranchTarget(BranchTarget), .JrTarget(JrTarget), .InstrIn(InstrIn),
        .CntClr(CntClr), .PC(PC), .IFID_Instr(IFID_Instr),
        .IFID_PCPlus4(IFID_PCPlus4), .IFID_Valid(IFID_Valid),
        .IDEX_Kill(IDEX_Kill), .StallCnt(StallCnt), .BubbleCnt(BubbleCnt),
        .RedirectCnt(RedirectCnt)
    );

    if_stage_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(2)) dut_small (
        .Clk(Clk), .Rst(Rst), .IF_write(IF_write), .PC_write(PC_write),
        .bubble(bubble), .addrSel(addrSel), .JumpField(JumpField),
        .BranchTarget(BranchTarget), .JrTarget(JrTarget), .InstrIn(InstrIn),
        .CntClr(CntClr), .PC(s_PC), .IFID_Instr(s_IFID_Instr),
        .IFID_PCPlus4(s_IFID_PCPlus4), .IFID_Valid(s_IFID_Valid),
        .IDEX_Kill(s_IDEX_Kill), .StallCnt(s_StallCnt), .BubbleCnt(s_BubbleCnt),
        .RedirectCnt(s_RedirectCnt)
    );

    // Reference model: fetch state as plain values, counters as unbounded
    // integers clamped at each instance's ceiling.
    logic [31:0] m_pc, m_instr, m_pp4;
    logic        m_valid, m_kill;
    longint      m_stall[2], m_bub[2], m_red[2];
    longint      cap[2];

    function automatic longint bump(longint v, longint c);
        return (v + 1 > c) ? c : v + 1;
    endfunction

    task automatic model_step();
        logic [31:0] seq_pc, tgt;
        if (!Rst) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0;
            m_valid = 1'b0; m_kill = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_stall[k] = 0; m_bub[k] = 0; m_red[k] = 0;
            end
        end else begin
            seq_pc = m_pc + 32'd4;
            case (addrSel)
                2'd0: tgt = seq_pc;
                2'd1: tgt = {m_pp4[31:28], JumpField, 2'b00};
                2'd2: tgt = BranchTarget;
                default: tgt = JrTarget;
            endcase
            for (int k = 0; k < 2; k++) begin
                if (CntClr) begin
                    m_stall[k] = 0; m_bub[k] = 0; m_red[k] = 0;
                end else begin
                    if (!PC_write) m_stall[k] = bump(m_stall[k], cap[k]);
                    if (bubble)    m_bub[k]   = bump(m_bub[k], cap[k]);
                    if (PC_write && addrSel != 2'd0) m_red[k] = bump(m_red[k], cap[k]);
                end
            end
            if (IF_write) begin
                m_instr = InstrIn; m_pp4 = seq_pc; m_valid = 1'b1;
            end
            if (PC_write) m_pc = tgt;
            m_kill = bubble;
        end
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock, update the model, then sample 1 ns after the edge.
    task automatic tick();
        @(posedge Clk);
        model_step();
        #1;
    endtask

    task automatic check_vs_model();
        chk("m_pc",    longint'(PC),           longint'(m_pc));
        chk("m_instr", longint'(IFID_Instr),   longint'(m_instr));
        chk("m_pp4",   longint'(IFID_PCPlus4), longint'(m_pp4));
        chk("m_valid", longint'(IFID_Valid),   longint'(m_valid));
        chk("m_kill",  longint'(IDEX_Kill),    longint'(m_kill));
        chk("m_stall", longint'(StallCnt),     m_stall[0]);
        chk("m_bub",   longint'(BubbleCnt),    m_bub[0]);
        chk("m_red",   longint'(RedirectCnt),  m_red[0]);
        chk("m_s_pc",    longint'(s_PC),          longint'(m_pc));
        chk("m_s_stall", longint'(s_StallCnt),    m_stall[1]);
        chk("m_s_bub",   longint'(s_BubbleCnt),   m_bub[1]);
        chk("m_s_red",   longint'(s_RedirectCnt), m_red[1]);
    endtask

    typedef struct {
        logic        rst, ifw, pcw, bub, clr;
        logic [1:0]  sel;
        logic [25:0] jf;
        logic [31:0] bt, jr, instr;
        logic [31:0] e_pc, e_instr, e_pp4;
        logic        e_valid, e_kill;
        int          e_stall, e_bub, e_red;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic rst, logic ifw, logic pcw, logic bub, logic clr,
                               logic [1:0] sel, logic [25:0] jf, logic [31:0] bt,
                               logic [31:0] jr, logic [31:0] instr,
                               logic [31:0] e_pc, logic [31:0] e_instr, logic [31:0] e_pp4,
                               logic e_valid, logic e_kill, int e_stall, int e_bub, int e_red);
        vec_t r;
        r.rst = rst; r.ifw = ifw; r.pcw = pcw; r.bub = bub; r.clr = clr;
        r.sel = sel; r.jf = jf; r.bt = bt; r.jr = jr; r.instr = instr;
        r.e_pc = e_pc; r.e_instr = e_instr; r.e_pp4 = e_pp4;
        r.e_valid = e_valid; r.e_kill = e_kill;
        r.e_stall = e_stall; r.e_bub = e_bub; r.e_red = e_red;
        return r;
    endfunction

    task automatic drive(input logic rst, input logic ifw, input logic pcw, input logic bub,
                         input logic clr, input logic [1:0] sel, input logic [25:0] jf,
                         input logic [31:0] bt, input logic [31:0] jr, input logic [31:0] instr);
        Rst = rst; IF_write = ifw; PC_write = pcw; bubble = bub; CntClr = clr;
        addrSel = sel; JumpField = jf; BranchTarget = bt; JrTarget = jr; InstrIn = instr;
    endtask

    initial begin
        cap[0] = 64'h0000_0000_FFFF_FFFF;
        cap[1] = 3;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 26'h0, 32'h0, 32'h0, 32'h0);

        //          rst ifw pcw bub clr sel    jf        bt             jr            instr
        //          e_pc           e_instr        e_pp4          vld kil st bu rd
        tbl.push_back(v(0,1,1,1,0, 2'd2, 26'h0,   32'h0000_0200, 32'h0,        32'hDEAD_BEEF,
                        32'h0,          32'h0,          32'h0,          0,0, 0,0,0));
        tbl.push_back(v(1,1,1,0,0, 2'd0, 26'h0,   32'h0,         32'h0,        32'hA000_0001,
                        32'h4,          32'hA000_0001, 32'h4,          1,0, 0,0,0));
        tbl.push_back(v(1,1,1,0,0, 2'd0, 26'h0,   32'h0,         32'h0,        32'hA000_0002,
                        32'h8,          32'hA000_0002, 32'h8,          1,0, 0,0,0));
        tbl.push_back(v(1,1,1,0,0, 2'd0, 26'h0,   32'h0,         32'h0,        32'hA000_0003,
                        32'hC,          32'hA000_0003, 32'hC,          1,0, 0,0,0));
        tbl.push_back(v(1,1,1,0,0, 2'd2, 26'h0,   32'h1000_0004, 32'h0,        32'hA000_0004,
                        32'h1000_0004, 32'hA000_0004, 32'h10,         1,0, 0,0,1));
        tbl.push_back(v(1,1,1,0,0, 2'd0, 26'h0,   32'h0,         32'h0,        32'hA000_0005,
                        32'h1000_0008, 32'hA000_0005, 32'h1000_0008, 1,0, 0,0,1));
        tbl.push_back(v(1,0,1,0,0, 2'd1, 26'h100, 32'h0,         32'h0,        32'hA000_0006,
                        32'h1000_0400, 32'hA000_0005, 32'h1000_0008, 1,0, 0,0,2));
        tbl.push_back(v(1,0,0,1,0, 2'd0, 26'h0,   32'h0,         32'h0,        32'hA000_0007,
                        32'h1000_0400, 32'hA000_0005, 32'h1000_0008, 1,1, 1,1,2));
        tbl.push_back(v(1,0,0,1,0, 2'd0, 26'h0,   32'h0,         32'h0,        32'hA000_0007,
                        32'h1000_0400, 32'hA000_0005, 32'h1000_0008, 1,1, 2,2,2));
        tbl.push_back(v(1,0,1,0,0, 2'd2, 26'h0,   32'h0000_0040, 32'h0,        32'hA000_0008,
                        32'h40,         32'hA000_0005, 32'h1000_0008, 1,0, 2,2,3));
        tbl.push_back(v(1,0,1,0,0, 2'd3, 26'h0,   32'h0,         32'h0000_0100, 32'hA000_0009,
                        32'h100,        32'hA000_0005, 32'h1000_0008, 1,0, 2,2,4));
        tbl.push_back(v(1,1,0,0,0, 2'd3, 26'h0,   32'h0,         32'h0000_0800, 32'hA000_000A,
                        32'h100,        32'hA000_000A, 32'h104,        1,0, 3,2,4));
        tbl.push_back(v(1,0,1,0,0, 2'd2, 26'h0,   32'hFFFF_FFFC, 32'h0,        32'hA000_000B,
                        32'hFFFF_FFFC, 32'hA000_000A, 32'h104,        1,0, 3,2,5));
        tbl.push_back(v(1,1,1,0,0, 2'd0, 26'h0,   32'h0,         32'h0,        32'hA000_000C,
                        32'h0,          32'hA000_000C, 32'h0,          1,0, 3,2,5));
        tbl.push_back(v(1,0,0,1,1, 2'd0, 26'h0,   32'h0,         32'h0,        32'hA000_000D,
                        32'h0,          32'hA000_000C, 32'h0,          1,1, 0,0,0));
        tbl.push_back(v(0,1,1,0,0, 2'd2, 26'h0,   32'h0000_0200, 32'h0,        32'hA000_000E,
                        32'h0,          32'h0,          32'h0,          0,0, 0,0,0));

        @(negedge Clk);
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].ifw, tbl[i].pcw, tbl[i].bub, tbl[i].clr,
                  tbl[i].sel, tbl[i].jf, tbl[i].bt, tbl[i].jr, tbl[i].instr);
            tick();
            chk("pc",       longint'(PC),           longint'(tbl[i].e_pc));
            chk("ifid_ins", longint'(IFID_Instr),   longint'(tbl[i].e_instr));
            chk("ifid_pp4", longint'(IFID_PCPlus4), longint'(tbl[i].e_pp4));
            chk("valid",    longint'(IFID_Valid),   longint'(tbl[i].e_valid));
            chk("kill",     longint'(IDEX_Kill),    longint'(tbl[i].e_kill));
            chk("stall",    longint'(StallCnt),     longint'(tbl[i].e_stall));
            chk("bubble",   longint'(BubbleCnt),    longint'(tbl[i].e_bub));
            chk("redirect", longint'(RedirectCnt),  longint'(tbl[i].e_red));
        end

        // Five stall cycles: the 2-bit instance must park at 3.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 26'h0, 32'h0, 32'h0, 32'h0);
            tick();
        end
        chk("sat_small_stall", longint'(s_StallCnt), 3);
        chk("sat_big_stall",   longint'(StallCnt),   5);
        chk("sat_hold_pc",     longint'(s_PC),       0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 26'h0, 32'h0, 32'h0, 32'h0);
        tick();
        chk("clr_small_stall", longint'(s_StallCnt), 0);
        chk("clr_big_stall",   longint'(StallCnt),   0);

        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 39) != 0), 1'($urandom), 1'($urandom),
                  1'($urandom), ($urandom_range(0, 29) == 0), 2'($urandom),
                  26'($urandom), $urandom, $urandom, $urandom);
            // Bias toward long stall runs so the narrow counters saturate.
            if (i % 100 > 80) begin
                PC_write = 1'b0; bubble = 1'b1; CntClr = 1'b0; Rst = 1'b1;
            end
            tick();
            check_vs_model();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
